// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: assembles INST_LEN-bit instructions from a narrow beat
// stream and buffers them in a first-word-fall-through queue for topcontrol.
// Sticky status flags report framing errors and pops from an empty queue.

module inst_fetch_queue #(
  parameter int INST_LEN  = 220,
  parameter int BEAT_LEN  = 32,
  parameter int DEPTH_LOG = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 soft_clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BEAT_LEN-1:0]  in_data,
  input  logic                 in_last,
  output logic [INST_LEN-1:0]  instruct,
  output logic                 inst_empty,
  input  logic                 inst_req,
  output logic [DEPTH_LOG:0]   inst_level,
  output logic                 frame_err,
  output logic                 underflow_err
);

  // Beats per instruction, rounded up; the last beat may carry fewer
  // meaningful bits than BEAT_LEN.
  localparam int BEATS  = (INST_LEN + BEAT_LEN - 1) / BEAT_LEN;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int ASM_W  = (BEATS - 1) * BEAT_LEN;
  localparam int LAST_W = INST_LEN - ASM_W;
  localparam int DEPTH  = 1 << DEPTH_LOG;

  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(BEATS - 1);
  localparam logic [DEPTH_LOG:0] FULL_LVL = (DEPTH_LOG + 1)'(DEPTH);

  // Assembler state: beats 0..BEATS-2 are held here; the final beat is
  // merged straight from in_data at push time and never stored.
  logic [CNT_W-1:0]     beat_cnt;
  logic [ASM_W-1:0]     asm_reg;

  // Queue storage and bookkeeping.
  logic [INST_LEN-1:0]  mem [DEPTH];
  logic [DEPTH_LOG-1:0] rd_ptr;
  logic [DEPTH_LOG-1:0] wr_ptr;
  logic [DEPTH_LOG:0]   level;
  logic                 frame_err_r;
  logic                 underflow_r;

  logic                 at_last;
  logic                 beat_fire;
  logic                 do_push;
  logic                 do_pop;
  logic                 bad_frame;
  logic [INST_LEN-1:0]  push_word;

  // Bits of the final beat above INST_LEN are intentionally ignored.
  logic                 unused_in_data;

  assign at_last   = (beat_cnt == LAST_CNT);
  assign in_ready  = !(at_last && (level == FULL_LVL));
  assign beat_fire = in_valid && in_ready;

  // A well-formed word closes exactly on the last beat with in_last set;
  // any other combination of in_last and position is a framing error.
  assign do_push   = beat_fire && at_last && in_last && !soft_clear;
  assign bad_frame = beat_fire && (at_last != in_last) && !soft_clear;
  assign do_pop    = inst_req && (level != '0) && !soft_clear;

  assign push_word      = {in_data[LAST_W-1:0], asm_reg};
  assign unused_in_data = ^in_data;

  assign inst_empty    = (level == '0);
  assign inst_level    = level;
  assign instruct      = inst_empty ? '0 : mem[rd_ptr];
  assign frame_err     = frame_err_r;
  assign underflow_err = underflow_r;

  // Assembler: store partial beats at their slot, restart on any word end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
      asm_reg  <= '0;
    end else if (soft_clear) begin
      beat_cnt <= '0;
      asm_reg  <= '0;
    end else if (beat_fire) begin
      if (at_last || in_last) begin
        beat_cnt <= '0;
        asm_reg  <= '0;
      end else begin
        for (int k = 0; k < BEATS - 1; k++) begin
          if (beat_cnt == CNT_W'(k)) begin
            asm_reg[k*BEAT_LEN +: BEAT_LEN] <= in_data;
          end
        end
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

  // Queue RAM write port; contents need no reset since level gates reads.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_word;
    end
  end

  // Pointers and occupancy; simultaneous push and pop keep the level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else if (soft_clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Sticky error flags, cleared only by reset or soft_clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err_r <= 1'b0;
      underflow_r <= 1'b0;
    end else if (soft_clear) begin
      frame_err_r <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (bad_frame) begin
        frame_err_r <= 1'b1;
      end
      if (inst_req && inst_empty) begin
        underflow_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: scenario tasks plus a randomized run, all checked
// against a queue-based reference model of the instruction front-end.

module tb_inst_fetch_queue;

  localparam int INST_LEN  = 220;
  localparam int BEAT_LEN  = 32;
  localparam int DEPTH_LOG = 6;
  localparam int BEATS     = 7;
  localparam int DEPTH     = 64;

  logic                clk;
  logic                rst_n;
  logic                soft_clear;
  logic                in_valid;
  logic                in_ready;
  logic [BEAT_LEN-1:0] in_data;
  logic                in_last;
  logic [INST_LEN-1:0] instruct;
  logic                inst_empty;
  logic                inst_req;
  logic [DEPTH_LOG:0]  inst_level;
  logic                frame_err;
  logic                underflow_err;

  int n_checks;
  int n_fail;

  // Reference model: completed instructions, beats of the word in flight,
  // and the two sticky flags.
  logic [INST_LEN-1:0] mq [$];
  logic [BEAT_LEN-1:0] pb [$];
  logic                m_ferr;
  logic                m_uerr;

  inst_fetch_queue #(
    .INST_LEN (INST_LEN),
    .BEAT_LEN (BEAT_LEN),
    .DEPTH_LOG(DEPTH_LOG)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .soft_clear   (soft_clear),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .instruct     (instruct),
    .inst_empty   (inst_empty),
    .inst_req     (inst_req),
    .inst_level   (inst_level),
    .frame_err    (frame_err),
    .underflow_err(underflow_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [INST_LEN-1:0] exp_inst();
    if (mq.size() > 0) return mq[0];
    return '0;
  endfunction

  function automatic logic exp_ready();
    return !((pb.size() == BEATS - 1) && (mq.size() == DEPTH));
  endfunction

  function automatic logic [INST_LEN-1:0] rand_word();
    logic [INST_LEN-1:0] w;
    for (int i = 0; i < INST_LEN; i += 32) w[i +: 1] = 1'b0;
    for (int i = 0; i < INST_LEN; i++) w[i] = 1'($urandom);
    return w;
  endfunction

  task automatic model_reset();
    mq.delete();
    pb.delete();
    m_ferr = 1'b0;
    m_uerr = 1'b0;
  endtask

  // One clock of stimulus; the model follows the rules on the pre-edge state.
  task automatic drive_cycle(input logic v, input logic [BEAT_LEN-1:0] d,
                             input logic l, input logic r, input logic c);
    logic rdy;
    logic [BEATS*BEAT_LEN-1:0] full;
    in_valid   = v;
    in_data    = d;
    in_last    = l;
    inst_req   = r;
    soft_clear = c;
    rdy = exp_ready();
    @(posedge clk);
    if (c) begin
      model_reset();
    end else begin
      if (r) begin
        if (mq.size() > 0) mq.delete(0);
        else m_uerr = 1'b1;
      end
      if (v && rdy) begin
        if (pb.size() == BEATS - 1) begin
          if (l) begin
            full = '0;
            for (int i = 0; i < BEATS - 1; i++) full[i*BEAT_LEN +: BEAT_LEN] = pb[i];
            full[(BEATS-1)*BEAT_LEN +: BEAT_LEN] = d;
            mq.push_back(full[INST_LEN-1:0]);
          end else begin
            m_ferr = 1'b1;
          end
          pb.delete();
        end else if (l) begin
          m_ferr = 1'b1;
          pb.delete();
        end else begin
          pb.push_back(d);
        end
      end
    end
    #1;
    in_valid   = 1'b0;
    in_data    = '0;
    in_last    = 1'b0;
    inst_req   = 1'b0;
    soft_clear = 1'b0;
  endtask

  task automatic send_beats(input logic [INST_LEN-1:0] w, input int nbeats,
                            input int last_at);
    logic [BEATS*BEAT_LEN-1:0] pad;
    pad = {4'($urandom), w};
    for (int k = 0; k < nbeats; k++)
      drive_cycle(1'b1, pad[k*BEAT_LEN +: BEAT_LEN], k == last_at, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    inst_req = 1'b0; soft_clear = 1'b0;
    model_reset();
    #12;
    n_checks++;
    if (inst_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", inst_empty); end
    n_checks++;
    if (inst_level !== 7'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", inst_level); end
    n_checks++;
    if (instruct !== '0) begin n_fail++; $display("FAIL reset_instruct: got %h want 0", instruct); end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    n_checks++;
    if ({frame_err, underflow_err} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b want 00", {frame_err, underflow_err}); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    for (int k = 0; k < BEATS; k++) begin
      drive_cycle(1'b1, 32'(k + 1), k == BEATS - 1, 1'b0, 1'b0);
      if (k == BEATS - 2) begin
        n_checks++;
        if (inst_empty !== 1'b1) begin n_fail++; $display("FAIL basic_early_empty: got %b want 1", inst_empty); end
      end
    end
    n_checks++;
    if (inst_empty !== 1'b0) begin n_fail++; $display("FAIL basic_empty: got %b want 0", inst_empty); end
    n_checks++;
    if (instruct[31:0] !== 32'h1) begin n_fail++; $display("FAIL basic_low: got %h want 1", instruct[31:0]); end
    n_checks++;
    if (instruct[219:192] !== 28'h0000007) begin n_fail++; $display("FAIL basic_high: got %h want 0000007", instruct[219:192]); end
    n_checks++;
    if (instruct !== exp_inst()) begin n_fail++; $display("FAIL basic_word: got %h want %h", instruct, exp_inst()); end
    n_checks++;
    if (inst_level !== 7'd1) begin n_fail++; $display("FAIL basic_level: got %0d want 1", inst_level); end
    drive_cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_order();
    logic [INST_LEN-1:0] w [3];
    for (int i = 0; i < 3; i++) begin
      w[i] = rand_word();
      send_beats(w[i], BEATS, BEATS - 1);
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (instruct !== w[i]) begin n_fail++; $display("FAIL order_head%0d: got %h want %h", i, instruct, w[i]); end
      drive_cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
      idle(2);
    end
    n_checks++;
    if (inst_empty !== 1'b1) begin n_fail++; $display("FAIL order_empty: got %b want 1", inst_empty); end
    n_checks++;
    if (underflow_err !== 1'b0) begin n_fail++; $display("FAIL order_underflow: got %b want 0", underflow_err); end
  endtask

  task automatic test_full();
    logic [INST_LEN-1:0] w65;
    logic [BEATS*BEAT_LEN-1:0] pad;
    drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) send_beats(rand_word(), BEATS, BEATS - 1);
    n_checks++;
    if (inst_level !== 7'd64) begin n_fail++; $display("FAIL full_level: got %0d want 64", inst_level); end
    w65 = rand_word();
    pad = {4'hA, w65};
    for (int k = 0; k < BEATS - 1; k++) begin
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_partial%0d: got %b want 1", k, in_ready); end
      drive_cycle(1'b1, pad[k*BEAT_LEN +: BEAT_LEN], 1'b0, 1'b0, 1'b0);
    end
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_last: got %b want 0", in_ready); end
    drive_cycle(1'b1, pad[(BEATS-1)*BEAT_LEN +: BEAT_LEN], 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_reopen: got %b want 1", in_ready); end
    n_checks++;
    if (inst_level !== 7'd63) begin n_fail++; $display("FAIL full_level_pop: got %0d want 63", inst_level); end
    drive_cycle(1'b1, pad[(BEATS-1)*BEAT_LEN +: BEAT_LEN], 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (inst_level !== 7'd64) begin n_fail++; $display("FAIL full_level_65: got %0d want 64", inst_level); end
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++;
      if (instruct !== exp_inst()) begin n_fail++; $display("FAIL full_drain%0d: got %h want %h", i, instruct, exp_inst()); end
      if (i == DEPTH - 1) begin
        n_checks++;
        if (instruct !== w65) begin n_fail++; $display("FAIL full_last_word: got %h want %h", instruct, w65); end
      end
      drive_cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    end
    n_checks++;
    if (inst_empty !== 1'b1) begin n_fail++; $display("FAIL full_drained: got %b want 1", inst_empty); end
  endtask

  task automatic test_frame();
    logic [INST_LEN-1:0] w;
    drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    send_beats(rand_word(), 3, 2);
    n_checks++;
    if (frame_err !== 1'b1) begin n_fail++; $display("FAIL frame_early_flag: got %b want 1", frame_err); end
    n_checks++;
    if (inst_level !== 7'd0) begin n_fail++; $display("FAIL frame_early_level: got %0d want 0", inst_level); end
    w = rand_word();
    send_beats(w, BEATS, BEATS - 1);
    n_checks++;
    if (inst_level !== 7'd1) begin n_fail++; $display("FAIL frame_recover_level: got %0d want 1", inst_level); end
    n_checks++;
    if (instruct !== w) begin n_fail++; $display("FAIL frame_recover_word: got %h want %h", instruct, w); end
    drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    send_beats(rand_word(), BEATS, -1);
    n_checks++;
    if (frame_err !== 1'b1) begin n_fail++; $display("FAIL frame_missing_last: got %b want 1", frame_err); end
    w = rand_word();
    send_beats(w, BEATS, BEATS - 1);
    n_checks++;
    if (instruct !== w || inst_level !== 7'd1) begin n_fail++; $display("FAIL frame_missing_recover: got %h/%0d want %h/1", instruct, inst_level, w); end
    drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL frame_clear: got %b want 0", frame_err); end
  endtask

  task automatic test_underflow();
    drive_cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (underflow_err !== 1'b1) begin n_fail++; $display("FAIL underflow_flag: got %b want 1", underflow_err); end
    n_checks++;
    if (inst_level !== 7'd0 || inst_empty !== 1'b1) begin n_fail++; $display("FAIL underflow_level: got %0d/%b want 0/1", inst_level, inst_empty); end
    idle(2);
    n_checks++;
    if (underflow_err !== 1'b1) begin n_fail++; $display("FAIL underflow_sticky: got %b want 1", underflow_err); end
    drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (underflow_err !== 1'b0) begin n_fail++; $display("FAIL underflow_clear: got %b want 0", underflow_err); end
  endtask

  task automatic test_push_pop();
    logic [BEATS*BEAT_LEN-1:0] pad;
    for (int i = 0; i < 5; i++) send_beats(rand_word(), BEATS, BEATS - 1);
    pad = {4'h5, rand_word()};
    for (int k = 0; k < BEATS - 1; k++)
      drive_cycle(1'b1, pad[k*BEAT_LEN +: BEAT_LEN], 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, pad[(BEATS-1)*BEAT_LEN +: BEAT_LEN], 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (inst_level !== 7'd5) begin n_fail++; $display("FAIL pushpop_level: got %0d want 5", inst_level); end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (instruct !== exp_inst()) begin n_fail++; $display("FAIL pushpop_order%0d: got %h want %h", i, instruct, exp_inst()); end
      drive_cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    end
    n_checks++;
    if (inst_empty !== 1'b1) begin n_fail++; $display("FAIL pushpop_empty: got %b want 1", inst_empty); end
  endtask

  task automatic test_reset_mid();
    logic [INST_LEN-1:0] w;
    send_beats(rand_word(), BEATS, BEATS - 1);
    send_beats(rand_word(), BEATS, BEATS - 1);
    send_beats(rand_word(), 4, -1);
    drive_cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b0;
    model_reset();
    #2;
    n_checks++;
    if (inst_level !== 7'd0 || inst_empty !== 1'b1) begin n_fail++; $display("FAIL midreset_level: got %0d/%b want 0/1", inst_level, inst_empty); end
    n_checks++;
    if (instruct !== '0) begin n_fail++; $display("FAIL midreset_instruct: got %h want 0", instruct); end
    n_checks++;
    if ({in_ready, frame_err, underflow_err} !== 3'b100) begin n_fail++; $display("FAIL midreset_flags: got %b want 100", {in_ready, frame_err, underflow_err}); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    w = rand_word();
    send_beats(w, BEATS, BEATS - 1);
    n_checks++;
    if (instruct !== w || inst_level !== 7'd1) begin n_fail++; $display("FAIL midreset_fresh: got %h/%0d want %h/1", instruct, inst_level, w); end
    n_checks++;
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL midreset_noframe: got %b want 0", frame_err); end
    drive_cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    int pop_pct;
    logic v, l, r, c;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      pop_pct = (cyc < 500) ? 5 : ((cyc < 1000) ? 40 : 15);
      v = ($urandom_range(0, 99) < 85);
      l = (pb.size() == BEATS - 1);
      if ($urandom_range(0, 99) < 4) l = ~l;
      r = ($urandom_range(0, 99) < pop_pct);
      c = ($urandom_range(0, 999) < 3);
      drive_cycle(v, $urandom, l, r, c);
      n_checks++;
      if (inst_level !== 7'(mq.size())) begin n_fail++; $display("FAIL rand_level@%0d: got %0d want %0d", cyc, inst_level, mq.size()); end
      n_checks++;
      if (inst_empty !== (mq.size() == 0)) begin n_fail++; $display("FAIL rand_empty@%0d: got %b want %b", cyc, inst_empty, mq.size() == 0); end
      n_checks++;
      if (instruct !== exp_inst()) begin n_fail++; $display("FAIL rand_instruct@%0d: got %h want %h", cyc, instruct, exp_inst()); end
      n_checks++;
      if (in_ready !== exp_ready()) begin n_fail++; $display("FAIL rand_ready@%0d: got %b want %b", cyc, in_ready, exp_ready()); end
      n_checks++;
      if ({frame_err, underflow_err} !== {m_ferr, m_uerr}) begin n_fail++; $display("FAIL rand_flags@%0d: got %b want %b", cyc, {frame_err, underflow_err}, {m_ferr, m_uerr}); end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic();
    test_order();
    test_full();
    test_frame();
    test_underflow();
    test_push_pop();
    test_reset_mid();
    drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
Instruction front-end that sits directly upstream of topcontrol. It assembles INST_LEN-bit instructions from a narrow beat stream (host/DMA side) and buffers them in a first-word-fall-through queue. It presents them on instruct/inst_empty and retires one instruction per cycle of inst_req. Sticky status flags report framing errors and underflow to the host.

Parameters:
INST_LEN, 220, instruction width; must equal topcontrol INST_LEN
BEAT_LEN, 32, input beat width
DEPTH_LOG, 6, log2 of queue depth (64 instructions)
BEATS (localparam), ceil(INST_LEN/BEAT_LEN) = 7, beats per instruction

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
soft_clear  in  1  synchronous flush of assembler, queue and error flags
in_valid  in  1  beat valid
in_ready  out  1  beat accepted when in_valid && in_ready
in_data  in  BEAT_LEN  beat payload
in_last  in  1  marks final beat of an instruction
instruct  out  INST_LEN  head-of-queue instruction (FWFT)
inst_empty  out  1  queue empty
inst_req  in  1  pop strobe from topcontrol; one pop per high cycle
inst_level  out  DEPTH_LOG+1  instructions currently queued
frame_err  out  1  sticky: in_last misaligned with beat count
underflow_err  out  1  sticky: inst_req while empty

Behaviour:
- Reset (async, rst_n=0):
  - beat_cnt=0, assembly register=0, rd_ptr=wr_ptr=0, inst_level=0.
  - inst_empty=1, frame_err=0, underflow_err=0.
  - instruct reads as 0; queue RAM contents are don't-care.
  - Reset mid-instruction discards the partial word.
- soft_clear=1: same effect as reset on the next edge; it overrides any simultaneous beat or pop.
- Assembler:
  - Beat k (beat_cnt=k) is written to assembly bits [k*BEAT_LEN +: BEAT_LEN], truncated at INST_LEN. Bits of the final beat above INST_LEN are ignored.
  - beat_cnt increments on each accepted beat and wraps to 0 after BEATS-1.
- Framing:
  - Accepted beat with beat_cnt==BEATS-1 and in_last=1: the complete word is pushed to the queue and beat_cnt goes to 0.
  - in_last=1 with beat_cnt<BEATS-1, or in_last=0 with beat_cnt==BEATS-1: set frame_err, drop the partial word (no push), beat_cnt goes to 0.
  - The offending beat itself is discarded.
- in_ready (combinational):
  - 0 only when beat_cnt==BEATS-1 and inst_level==2^DEPTH_LOG.
  - Partial beats are always accepted.
  - A pop in the same cycle does not reopen in_ready; it reopens the following cycle.
- Queue (FWFT):
  - instruct = mem[rd_ptr] whenever inst_empty=0.
  - Pointers are DEPTH_LOG bits and wrap naturally.
  - Push and pop in the same cycle: level unchanged, both pointers advance.
- Pop:
  - inst_req=1 && inst_empty=0 advances rd_ptr at that edge.
  - instruct and inst_empty reflect the new head the next cycle.
  - topcontrol holds inst_req high exactly one cycle per issued instruction. Each high cycle pops exactly one entry; no edge detection is applied.
- Underflow: inst_req=1 with inst_empty=1 sets underflow_err; pointers and level are unchanged.
- Latency:
  - Final beat accepted at edge N; if the queue was empty, inst_empty falls and instruct is valid after edge N.
  - Write-to-read throughput is 1 instruction per cycle at the queue. Ingress is limited to 1 instruction per BEATS cycles.
- inst_level = wr-rd occupancy, range 0..2^DEPTH_LOG, registered and consistent with inst_empty (inst_empty == (inst_level==0)).
- Sticky flags clear only on rst_n or soft_clear.

Test Plan:
- Reset, then 7 beats 0x00000001..0x00000007 with in_last on beat 7 → inst_empty=0 the next cycle; instruct[31:0]=1, instruct[223-4...] truncated so instruct[219:192]=0x0000007; inst_level=1.
- Push 3 instructions A,B,C; pulse inst_req for one cycle three times with 2-cycle gaps → instruct shows A, B, C in order; inst_empty=1 after the third pop; underflow_err=0.
- Fill the queue to 64 and send 6 beats of a 65th → in_ready stays 1; the 7th beat sees in_ready=0. One pop → in_ready=1 the next cycle, the 65th instruction is pushed, inst_level=64.
- in_last on beat 3 → frame_err=1, nothing pushed, beat_cnt=0. The next 7 well-formed beats push one correct instruction.
- inst_req with queue empty → underflow_err=1, inst_level stays 0. Then soft_clear → underflow_err=0.
- Push on the same cycle as a pop at level 5 → inst_level stays 5 and order is preserved. Assert rst_n=0 after 4 beats of a partial word → all outputs at reset values, partial word lost.
